// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction memory loader. Rev 1.0
`default_nettype none

package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    ST_LEN  = 2'd0,
    ST_DATA = 2'd1,
    ST_CSUM = 2'd2,
    ST_DONE = 2'd3
  } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/imem_loader_byte_assembler.sv
// byte_assembler: 4-byte little-endian word assembler; o_word_valid pulses with the final byte.
`default_nettype none

module byte_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  localparam int SHW = 8 * (BYTES_PER_WORD - 1);

  logic [1:0]     r_idx;
  logic [SHW-1:0] r_shift;

  // Bytes enter at the top, so after three bytes the oldest sits in bits 7:0.
  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_idx   <= 2'd0;
      r_shift <= '0;
    end else if (i_accept) begin
      r_idx   <= r_idx + 2'd1;
      r_shift <= {i_byte, r_shift[SHW-1:8]};
    end
  end

  assign o_word       = {i_byte, r_shift};
  assign o_word_valid = i_accept & (r_idx == 2'(BYTES_PER_WORD - 1));

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed program into instruction memory, holding the CPU meanwhile. Rev 1.0
// Optional feature: define IMEM_LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
`default_nettype none

module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  localparam int            CW      = $clog2(DEPTH_WORDS) + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH_WORDS);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_t C_AFTER_DATA = ST_CSUM;
`else
  localparam loader_state_t C_AFTER_DATA = ST_DONE;
`endif

  loader_state_t r_state, w_next;
  logic [31:0]   r_remaining;
  logic [CW-1:0] r_widx;
  logic          r_ovf;
  logic          r_rx_ready, r_mem_we, r_cpu_hold, r_load_done, r_load_err;
  logic [31:0]   r_mem_addr, r_mem_wdata;

  logic          w_xfer, w_in_len, w_in_data, w_asm_accept;
  logic          w_word_valid, w_last_word, w_fits, w_write, w_ovf_now;
  logic          w_enter_done, w_err;
  logic [31:0]   w_word;

  assign w_xfer       = rx_valid & r_rx_ready;
  assign w_in_len     = (r_state == ST_LEN);
  assign w_in_data    = (r_state == ST_DATA);
  assign w_asm_accept = w_xfer & (w_in_len | w_in_data);

  byte_assembler u_asm (
    .clk          (clk),
    .i_clear      (rst),
    .i_accept     (w_asm_accept),
    .i_byte       (rx_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  // Words beyond the memory are still counted against N but never written.
  assign w_fits      = (r_widx < C_DEPTH);
  assign w_last_word = w_in_data & w_word_valid & (r_remaining == 32'd1);
  assign w_write     = w_in_data & w_word_valid & w_fits;
  assign w_ovf_now   = r_ovf | (w_in_data & w_word_valid & ~w_fits);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] r_csum;
  logic       w_csum_bad;

  assign w_csum_bad = (r_state == ST_CSUM) & w_xfer & (rx_data != r_csum);
  assign w_err      = w_ovf_now | w_csum_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_csum <= 8'h00;
    end else if (w_in_data & w_xfer) begin
      r_csum <= r_csum ^ rx_data;
    end
  end
`else
  assign w_err = w_ovf_now;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_LEN:  if (w_word_valid) w_next = (w_word == 32'd0) ? C_AFTER_DATA : ST_DATA;
      ST_DATA: if (w_last_word)  w_next = C_AFTER_DATA;
      ST_CSUM: if (w_xfer)       w_next = ST_DONE;
      default: w_next = ST_DONE;
    endcase
  end

  assign w_enter_done = (w_next == ST_DONE) & (r_state != ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_LEN;
      r_remaining <= 32'd0;
      r_widx      <= '0;
      r_ovf       <= 1'b0;
      r_rx_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= BASE_ADDR;
      r_mem_wdata <= 32'd0;
      r_cpu_hold  <= 1'b1;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_rx_ready  <= (w_next != ST_DONE);
      r_cpu_hold  <= (w_next != ST_DONE);
      r_load_done <= (w_next == ST_DONE);
      r_mem_we    <= w_write;
      r_ovf       <= w_ovf_now;
      if (w_in_len & w_word_valid) begin
        r_remaining <= w_word;
      end else if (w_in_data & w_word_valid) begin
        r_remaining <= r_remaining - 32'd1;
      end
      if (w_write) begin
        r_mem_addr  <= BASE_ADDR + (32'(r_widx) << 2);
        r_mem_wdata <= w_word;
        r_widx      <= r_widx + CW'(1);
      end
      if (w_enter_done) begin
        r_load_err <= w_err;
      end
    end
  end

  assign rx_ready  = r_rx_ready;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_hold  = r_cpu_hold;
  assign load_done = r_load_done;
  assign load_err  = r_load_err;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader (DEPTH_WORDS=2); honours IMEM_LOADER_CHECKSUM_EN.
`default_nettype none

module tb_imem_loader;

  localparam int          DEPTH = 2;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready, mem_we, cpu_hold, load_done, load_err;
  logic [31:0] mem_addr, mem_wdata;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;
  logic [31:0] wq[$];

  always #5 clk = ~clk;

  imem_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  // Every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", mem_addr, mem_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== mon_exp)
          begin
            bad++;
            $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                     mem_addr, mem_wdata, mon_exp[63:32], mon_exp[31:0]);
          end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int w;
    rx_data  = b;
    rx_valid = 1'b1;
    w = 0;
    while (rx_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (rx_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_timeout: rx_ready=%b after %0d cycles, expected 1", rx_ready, w);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Streams N then the words in wq; pushes expected writes and checks strobe timing.
  task automatic run_load(input logic [31:0] n, input bit gap, input bit bad_csum);
    logic [7:0]  x;
    logic [7:0]  b;
    logic [31:0] w;
    logic [31:0] a;
    x = 8'h00;
    for (int i = 0; i < 4; i++) begin
      send_byte(n[8*i +: 8]);
      if (gap) begin @(posedge clk); #1; end
    end
`ifndef IMEM_LOADER_CHECKSUM_EN
    if (n == 32'd0) begin
      total++;
      if (load_done !== 1'b1) begin
        bad++;
        $display("FAIL zero_len_done: load_done=%b, expected 1", load_done);
      end
    end
`endif
    for (int k = 0; k < wq.size(); k++) begin
      w = wq[k];
      for (int i = 0; i < 4; i++) begin
        b = w[8*i +: 8];
        x = x ^ b;
        if (i == 3 && k < DEPTH) begin
          a = BASE + (32'(k) << 2);
          exp_q.push_back({a, w});
        end
        send_byte(b);
        if (i == 3) begin
          total++;
          if (mem_we !== (k < DEPTH)) begin
            bad++;
            $display("FAIL we_timing: word %0d mem_we=%b, expected %b", k, mem_we, (k < DEPTH));
          end
        end
        if (gap) begin @(posedge clk); #1; end
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(bad_csum ? (x ^ 8'h01) : x);
`else
    if (bad_csum) x = 8'h00;
`endif
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({rx_ready, mem_we, cpu_hold, load_done, load_err} !== 5'b00100 ||
        mem_addr !== BASE || mem_wdata !== 32'd0) begin
      bad++;
      $display("FAIL reset_state: rdy=%b we=%b hold=%b done=%b err=%b addr=%h data=%h, expected 0 0 1 0 0 %h 0",
               rx_ready, mem_we, cpu_hold, load_done, load_err, mem_addr, mem_wdata, BASE);
    end
    @(posedge clk);
    #1;
    rst      = 1'b0;
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (rx_ready !== 1'b1 || cpu_hold !== 1'b1) begin
      bad++;
      $display("FAIL post_reset: rx_ready=%b cpu_hold=%b, expected 1 1", rx_ready, cpu_hold);
    end
  endtask

  task automatic test_basic();
    do_reset();
    wq = '{32'h0000_0013, 32'h0010_0093};
    run_load(32'd2, 1'b0, 1'b0);
    total++;
    if ({load_done, cpu_hold, load_err, rx_ready} !== 4'b1000) begin
      bad++;
      $display("FAIL basic_done: done=%b hold=%b err=%b rdy=%b, expected 1 0 0 0",
               load_done, cpu_hold, load_err, rx_ready);
    end
    rx_data  = 8'hAA;
    rx_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    total++;
    if (load_done !== 1'b1 || mem_addr !== 32'h4 || mem_wdata !== 32'h0010_0093) begin
      bad++;
      $display("FAIL done_hold: done=%b addr=%h data=%h, expected 1 00000004 00100093",
               load_done, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    wq.delete();
    run_load(32'd0, 1'b0, 1'b0);
    total++;
    if ({load_done, cpu_hold, load_err} !== 3'b100) begin
      bad++;
      $display("FAIL zero_len: done=%b hold=%b err=%b, expected 1 0 0", load_done, cpu_hold, load_err);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    wq = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    run_load(32'd3, 1'b0, 1'b0);
    total++;
    if ({load_done, load_err} !== 2'b11 || mem_addr !== 32'h4) begin
      bad++;
      $display("FAIL overflow: done=%b err=%b addr=%h, expected 1 1 00000004", load_done, load_err, mem_addr);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hEF); send_byte(8'hBE);
    rst      = 1'b1;
    rx_data  = 8'hAD;
    rx_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (load_done !== 1'b0 || mem_addr !== BASE || exp_q.size() != 0) begin
      bad++;
      $display("FAIL mid_reset: done=%b addr=%h pending=%0d, expected 0 %h 0",
               load_done, mem_addr, exp_q.size(), BASE);
    end
    wq = '{32'hDEAD_BEEF};
    run_load(32'd1, 1'b0, 1'b0);
    total++;
    if ({load_done, load_err} !== 2'b10 || mem_wdata !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL reload: done=%b err=%b data=%h, expected 1 0 deadbeef", load_done, load_err, mem_wdata);
    end
  endtask

  task automatic test_gapped();
    do_reset();
    wq = '{32'h0000_0013, 32'h0010_0093};
    run_load(32'd2, 1'b1, 1'b0);
    total++;
    if ({load_done, cpu_hold, load_err} !== 3'b100) begin
      bad++;
      $display("FAIL gapped_done: done=%b hold=%b err=%b, expected 1 0 0", load_done, cpu_hold, load_err);
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    wq = '{32'h0000_0013};
    run_load(32'd1, 1'b0, 1'b0);
    total++;
    if ({load_done, load_err} !== 2'b10) begin
      bad++;
      $display("FAIL csum_good: done=%b err=%b, expected 1 0", load_done, load_err);
    end
    do_reset();
    run_load(32'd1, 1'b0, 1'b1);
    total++;
    if ({load_done, load_err} !== 2'b11) begin
      bad++;
      $display("FAIL csum_bad: done=%b err=%b, expected 1 1", load_done, load_err);
    end
  endtask
`endif

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    test_reset();
    test_basic();
    test_zero_len();
    test_overflow();
    test_mid_reset();
    test_gapped();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_writes: %0d expected writes never seen, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: instruction memory capacity in 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of the first written word.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rx_data  input  8  incoming program byte.
REQ-006 rx_valid  input  1  rx_data valid.
REQ-007 rx_ready  output  1  loader accepts a byte; a transfer occurs on an edge where rx_valid and rx_ready are both 1.
REQ-008 mem_we  output  1  one-cycle write strobe to the imem write port.
REQ-009 mem_addr  output  32  byte address of the write, word-aligned.
REQ-010 mem_wdata  output  32  instruction word.
REQ-011 cpu_hold  output  1  holds the PC/fetch path in reset while loading.
REQ-012 load_done  output  1  load finished, level.
REQ-013 load_err  output  1  load finished with an error, level.

Function
REQ-014 The FSM SHALL use the states LEN, DATA, CSUM and DONE; CSUM exists only under REQ-030.
REQ-015 LEN: accept 4 bytes, little-endian, forming the word count N; the 4th byte moves the FSM to DATA, or straight to DONE when N=0.
REQ-016 DATA: every 4 accepted bytes form one word, little-endian (first byte = bits 7:0).
REQ-017 Write timing: mem_we=1 for exactly one cycle, in the cycle after the edge that accepted the word's 4th byte.
REQ-018 Write data: mem_addr=BASE_ADDR+4*k for word index k (0-based); mem_wdata holds the assembled word.
REQ-019 Outputs SHALL be registered; mem_addr and mem_wdata SHALL hold their last values when mem_we=0.
REQ-020 rx_ready=1 in LEN, DATA and CSUM, and 0 in DONE; back-to-back bytes (rx_valid held high) SHALL be accepted one per cycle with no stall.
REQ-021 Gaps in rx_valid SHALL not disturb byte assembly or counters.
REQ-022 Overflow: if N>DEPTH_WORDS, words with k>=DEPTH_WORDS SHALL be consumed but not written (mem_we stays 0), and load_err SHALL be set on entry to DONE.
REQ-023 After word N-1 is accepted: go to CSUM if REQ-030 is enabled, else to DONE.
REQ-024 DONE is terminal until rst.
REQ-025 In DONE: cpu_hold=0, load_done=1, and rx_valid is ignored.
REQ-026 Word counter width: $clog2(DEPTH_WORDS)+1 bits for the write index; N is a full 32 bits.

Reset
REQ-027 On rst: FSM=LEN, byte/word counters=0, cpu_hold=1, rx_ready=0 (1 from the first cycle after rst deasserts), mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, load_done=0, load_err=0, checksum=0.
REQ-028 rst asserted mid-load SHALL abandon any partial word without a write; the next load restarts at LEN and BASE_ADDR.
REQ-029 rst has priority over a simultaneous byte transfer; that byte is dropped.

Configuration
REQ-030 With IMEM_LOADER_CHECKSUM_EN defined:
- An 8-bit XOR of all DATA bytes is accumulated.
- After the last word, the FSM enters CSUM and accepts one byte.
- A mismatch sets load_err; the FSM then enters DONE.
- N=0 SHALL still pass through CSUM, with the expected value 8'h00.
REQ-031 Without IMEM_LOADER_CHECKSUM_EN: there is no CSUM state and no accumulator; load_err reflects overflow only.

Structure
REQ-032 The shared package imem_loader_pkg SHALL hold the state enum typedef (loader_state_t) and the byte-per-word constant (BYTES_PER_WORD=4).
REQ-033 One sub-module, byte_assembler, SHALL be used:
- 4-byte little-endian shift/assemble register with a 2-bit byte index.
- Signals word_valid for one cycle on completion.
- Clear input driven by rst.

Verification
REQ-034 Bytes 02 00 00 00, 13 00 00 00, 93 00 10 00 streamed back-to-back -> writes (0x0,0x00000013) then (0x4,0x00100093); then load_done=1, cpu_hold=0, load_err=0.
REQ-035 N=0 (00 00 00 00) -> no mem_we; DONE on the next cycle, load_done=1.
REQ-036 DEPTH_WORDS=2, N=3 with 12 data bytes -> exactly 2 writes; the 3rd word is consumed; load_err=1.
REQ-037 rst pulsed after 2 bytes of word 1 -> no write; a reload of N=1 word 0xDEADBEEF writes 0xDEADBEEF to BASE_ADDR.
REQ-038 rx_valid toggled 1/0 every cycle during the REQ-034 stream -> identical writes, each mem_we one cycle after its 4th byte.
REQ-039 IMEM_LOADER_CHECKSUM_EN, data 13 00 00 00: checksum byte 0x13 -> load_err=0; checksum byte 0x12 -> load_err=1.
